// File: rtl/muldiv_requester_pkg.sv
// Shared definitions for the M-extension requester. It holds the funct3 operation codes, the
// FSM state encoding, the operand width the engine supports, and the helpers that decide which
// operands are treated as signed.
package muldiv_requester_pkg;

    // The iterative engine is fixed at 32-bit operands.
    localparam int unsigned MdWidth = 32;

    typedef enum logic [2:0] {
        OpMul    = 3'd0,
        OpMulh   = 3'd1,
        OpMulhsu = 3'd2,
        OpMulhu  = 3'd3,
        OpDiv    = 3'd4,
        OpDivu   = 3'd5,
        OpRem    = 3'd6,
        OpRemu   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBusy  = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } state_e;

    // Operand A is treated as signed.
    function automatic logic op_sa(op_e op);
        return op inside {OpMulh, OpMulhsu, OpDiv, OpRem};
    endfunction

    // Operand B is treated as signed.
    function automatic logic op_sb(op_e op);
        return op inside {OpMulh, OpDiv, OpRem};
    endfunction

endpackage

// File: rtl/muldiv_requester_sign_fix.sv
// Combinational sign correction of the unsigned engine result.
// Ports:
//   op_i      operation (funct3)
//   na_i      operand A was negated before issue
//   nb_i      operand B was negated before issue
//   md_out_i  raw engine output: product, or {remainder, quotient}
//   result_o  final rd value
module muldiv_requester_sign_fix
    import muldiv_requester_pkg::*;
(
    input  op_e                    op_i,
    input  logic                   na_i,
    input  logic                   nb_i,
    input  logic [2*MdWidth-1:0]   md_out_i,
    output logic [MdWidth-1:0]     result_o
);

    logic [2*MdWidth-1:0] prod;
    logic [MdWidth-1:0]   quot;
    logic [MdWidth-1:0]   rem;

    always_comb begin
        // MULHSU never has nb set, so na^nb also covers the "na only" case there.
        prod = (na_i ^ nb_i) ? -md_out_i : md_out_i;
        quot = md_out_i[MdWidth-1:0];
        rem  = md_out_i[2*MdWidth-1:MdWidth];
        unique case (op_i)
            OpMul:                     result_o = prod[MdWidth-1:0];
            OpMulh, OpMulhsu, OpMulhu: result_o = prod[2*MdWidth-1:MdWidth];
            OpDiv, OpDivu:             result_o = (na_i ^ nb_i) ? -quot : quot;
            OpRem, OpRemu:             result_o = na_i ? -rem : rem;
            default:                   result_o = '0;
        endcase
    end

endmodule

// File: rtl/muldiv_requester.sv
// EX-stage initiator for the iterative unsigned multiply/divide engine. Converts RV32M operands
// to magnitudes, issues them to the engine, stalls the pipeline until the engine answers, and
// sign-corrects the answer. Division by zero and signed overflow are resolved locally.
//
// Optional feature macro: MULDIV_FUSE_EN -- keeps the last engine result and answers a matching
// request without re-issuing to the engine.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset (shared with the engine)
//   ex_req_i           M-op in EX, operands stable while stall_o is high
//   ex_op_i            funct3 of the op
//   ex_rs1_i/ex_rs2_i  operands
//   ex_kill_i          flush of the EX instruction
//   stall_o            freeze the pipeline
//   result_o           rd value, qualified by result_valid_o
//   result_valid_o     one-cycle result pulse
//   md_valid_o         one-cycle engine issue pulse
//   md_mode_o          0 multiply, 1 divide
//   md_in_a_o/b_o      operand magnitudes
//   md_ready_i         engine done, md_out_i valid this cycle only
//   md_out_i           product or {remainder, quotient}
module muldiv_requester
    import muldiv_requester_pkg::*;
#(
    parameter int unsigned XLEN = MdWidth
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_req_i,
    input  logic [2:0]        ex_op_i,
    input  logic [XLEN-1:0]   ex_rs1_i,
    input  logic [XLEN-1:0]   ex_rs2_i,
    input  logic              ex_kill_i,
    output logic              stall_o,
    output logic [XLEN-1:0]   result_o,
    output logic              result_valid_o,
    output logic              md_valid_o,
    output logic              md_mode_o,
    output logic [XLEN-1:0]   md_in_a_o,
    output logic [XLEN-1:0]   md_in_b_o,
    input  logic              md_ready_i,
    input  logic [2*XLEN-1:0] md_out_i
);

    localparam logic [XLEN-1:0] IntMin = {1'b1, {(XLEN-1){1'b0}}};

    state_e          state_q, state_d;
    op_e             op_q, op_d;
    logic            na_q, na_d;
    logic            nb_q, nb_d;
    logic [XLEN-1:0] result_q, result_d;

    op_e             op;
    logic            na, nb;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            accept;
    logic            rs2_zero, overflow, special;
    logic [XLEN-1:0] special_res;
    logic            fuse_hit;

    op_e             fix_op;
    logic            fix_na, fix_nb;
    logic [2*XLEN-1:0] fix_out;
    logic [XLEN-1:0] fix_result;

    // ------------------------------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------------------------------
    always_comb begin
        op    = op_e'(ex_op_i);
        na    = op_sa(op) & ex_rs1_i[XLEN-1];
        nb    = op_sb(op) & ex_rs2_i[XLEN-1];
        mag_a = na ? -ex_rs1_i : ex_rs1_i;
        mag_b = nb ? -ex_rs2_i : ex_rs2_i;

        // rst_n gates acceptance so that stall and issue read 0 while reset is held, even with
        // a request still presented by the pipeline.
        accept = ex_req_i & ~ex_kill_i & rst_n;

        rs2_zero = (ex_rs2_i == '0);
        overflow = (op inside {OpDiv, OpRem}) & (ex_rs1_i == IntMin) & (&ex_rs2_i);
        special  = ex_op_i[2] & (rs2_zero | overflow);

        // ex_op_i[1] separates REM/REMU from DIV/DIVU.
        if (rs2_zero) begin
            special_res = ex_op_i[1] ? ex_rs1_i : '1;
        end else begin
            special_res = ex_op_i[1] ? '0 : IntMin;
        end
    end

    // ------------------------------------------------------------------------------------------
    // Optional result reuse
    // ------------------------------------------------------------------------------------------
`ifdef MULDIV_FUSE_EN
    logic              fuse_set, fuse_clr;
    logic              fuse_valid_q, fuse_cls_q, fuse_sa_q, fuse_sb_q;
    logic [XLEN-1:0]   fuse_rs1_q, fuse_rs2_q;
    logic [2*XLEN-1:0] fuse_out_q;
    logic              iss_cls_q, iss_sa_q, iss_sb_q;
    logic [XLEN-1:0]   iss_rs1_q, iss_rs2_q;

    always_comb begin
        fuse_set = (state_q == StBusy) & ~ex_kill_i & md_ready_i;
        fuse_clr = (state_q == StDrain) | ((state_q == StBusy) & ex_kill_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fuse_valid_q <= 1'b0;
            fuse_cls_q   <= 1'b0;
            fuse_sa_q    <= 1'b0;
            fuse_sb_q    <= 1'b0;
            fuse_rs1_q   <= '0;
            fuse_rs2_q   <= '0;
            fuse_out_q   <= '0;
            iss_cls_q    <= 1'b0;
            iss_sa_q     <= 1'b0;
            iss_sb_q     <= 1'b0;
            iss_rs1_q    <= '0;
            iss_rs2_q    <= '0;
        end else begin
            if (md_valid_o) begin
                iss_cls_q <= ex_op_i[2];
                iss_sa_q  <= op_sa(op);
                iss_sb_q  <= op_sb(op);
                iss_rs1_q <= ex_rs1_i;
                iss_rs2_q <= ex_rs2_i;
            end
            if (fuse_set) begin
                fuse_valid_q <= 1'b1;
                fuse_cls_q   <= iss_cls_q;
                fuse_sa_q    <= iss_sa_q;
                fuse_sb_q    <= iss_sb_q;
                fuse_rs1_q   <= iss_rs1_q;
                fuse_rs2_q   <= iss_rs2_q;
                fuse_out_q   <= md_out_i;
            end else if (fuse_clr) begin
                fuse_valid_q <= 1'b0;
            end
        end
    end

    // Signedness is compared as applied to the operands: a signed/unsigned difference on a
    // non-negative operand leaves the engine inputs, and hence the raw output, unchanged.
    assign fuse_hit = fuse_valid_q & (fuse_cls_q == ex_op_i[2]) &
                      (fuse_rs1_q == ex_rs1_i) & (fuse_rs2_q == ex_rs2_i) &
                      ((fuse_sa_q & ex_rs1_i[XLEN-1]) == na) &
                      ((fuse_sb_q & ex_rs2_i[XLEN-1]) == nb);

    // In IDLE the corrector works on the stored output for the incoming op.
    always_comb begin
        if (state_q == StIdle) begin
            fix_op  = op;
            fix_na  = na;
            fix_nb  = nb;
            fix_out = fuse_out_q;
        end else begin
            fix_op  = op_q;
            fix_na  = na_q;
            fix_nb  = nb_q;
            fix_out = md_out_i;
        end
    end
`else
    assign fuse_hit = 1'b0;
    assign fix_op   = op_q;
    assign fix_na   = na_q;
    assign fix_nb   = nb_q;
    assign fix_out  = md_out_i;
`endif

    muldiv_requester_sign_fix u_sign_fix (
        .op_i     (fix_op),
        .na_i     (fix_na),
        .nb_i     (fix_nb),
        .md_out_i (fix_out),
        .result_o (fix_result)
    );

    // ------------------------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        na_d           = na_q;
        nb_d           = nb_q;
        result_d       = result_q;
        stall_o        = 1'b0;
        result_valid_o = 1'b0;
        md_valid_o     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    stall_o = 1'b1;
                    if (special) begin
                        result_d = special_res;
                        state_d  = StDone;
                    end else if (fuse_hit) begin
                        result_d = fix_result;
                        state_d  = StDone;
                    end else begin
                        md_valid_o = 1'b1;
                        op_d       = op;
                        na_d       = na;
                        nb_d       = nb;
                        state_d    = StBusy;
                    end
                end
            end
            StBusy: begin
                stall_o = 1'b1;
                if (ex_kill_i) begin
                    // If the engine answers in the kill cycle there is nothing left to drain.
                    state_d = md_ready_i ? StIdle : StDrain;
                end else if (md_ready_i) begin
                    result_d = fix_result;
                    state_d  = StDone;
                end
            end
            StDrain: begin
                stall_o = ex_req_i;
                if (md_ready_i) begin
                    state_d = StIdle;
                end
            end
            StDone: begin
                // ex_req_i here is still the instruction just answered.
                result_valid_o = ~ex_kill_i;
                state_d        = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Operands are driven only with the issue pulse.
    always_comb begin
        md_mode_o = md_valid_o & ex_op_i[2];
        md_in_a_o = md_valid_o ? mag_a : '0;
        md_in_b_o = md_valid_o ? mag_b : '0;
    end

    assign result_o = result_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            op_q     <= OpMul;
            na_q     <= 1'b0;
            nb_q     <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            na_q     <= na_d;
            nb_q     <= nb_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_muldiv_requester.sv
// Directed bench for muldiv_requester with a behavioural 33-cycle unsigned engine.
module tb_muldiv_requester;

    logic        clk;
    logic        rst_n;
    logic        ex_req;
    logic [2:0]  ex_op;
    logic [31:0] ex_rs1;
    logic [31:0] ex_rs2;
    logic        ex_kill;
    logic        stall;
    logic [31:0] result;
    logic        result_valid;
    logic        md_valid;
    logic        md_mode;
    logic [31:0] md_in_a;
    logic [31:0] md_in_b;
    logic        md_ready;
    logic [63:0] md_out;

    int errors = 0;
    int checks = 0;

    muldiv_requester dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_req_i       (ex_req),
        .ex_op_i        (ex_op),
        .ex_rs1_i       (ex_rs1),
        .ex_rs2_i       (ex_rs2),
        .ex_kill_i      (ex_kill),
        .stall_o        (stall),
        .result_o       (result),
        .result_valid_o (result_valid),
        .md_valid_o     (md_valid),
        .md_mode_o      (md_mode),
        .md_in_a_o      (md_in_a),
        .md_in_b_o      (md_in_b),
        .md_ready_i     (md_ready),
        .md_out_i       (md_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Engine model: issue seen in cycle T, md_ready and md_out in cycle T+33 only.
    logic        eng_busy;
    int          eng_cnt;
    logic        eng_mode;
    logic [31:0] eng_a, eng_b;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_busy <= 1'b0;
            eng_cnt  <= 0;
            md_ready <= 1'b0;
            md_out   <= 64'hDEAD_BEEF_DEAD_BEEF;
        end else begin
            md_ready <= 1'b0;
            md_out   <= 64'hDEAD_BEEF_DEAD_BEEF;
            if (md_valid) begin
                eng_busy <= 1'b1;
                eng_cnt  <= 1;
                eng_mode <= md_mode;
                eng_a    <= md_in_a;
                eng_b    <= md_in_b;
            end else if (eng_busy) begin
                if (eng_cnt == 32) begin
                    eng_busy <= 1'b0;
                    md_ready <= 1'b1;
                    if (eng_mode) md_out <= {eng_a % eng_b, eng_a / eng_b};
                    else          md_out <= {32'd0, eng_a} * {32'd0, eng_b};
                end else begin
                    eng_cnt <= eng_cnt + 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Presents one op, waits for result_valid and checks value, latency, stall and issue.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                          input int exp_issues);
        int lat;
        int nvalid;
        bit stall_ok;
        bit issue_at_t;
        lat        = -1;
        nvalid     = 0;
        stall_ok   = 1'b1;
        issue_at_t = (exp_issues == 0);
        @(posedge clk); #1;
        ex_req = 1'b1;
        ex_op  = op;
        ex_rs1 = a;
        ex_rs2 = b;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (md_valid) begin
                nvalid++;
                if (k == 0) issue_at_t = 1'b1;
            end
            if (result_valid) begin
                lat = k;
                break;
            end
            if (!stall) stall_ok = 1'b0;
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " result"}, result, exp);
        check({tag, " stall at result"}, stall, 1'b0);
        check({tag, " issues"}, nvalid, exp_issues);
        check({tag, " stall while waiting"}, stall_ok, 1'b1);
        check({tag, " issue at T"}, issue_at_t, 1'b1);
        @(posedge clk); #1;
        ex_req = 1'b0;
        @(negedge clk);
        check({tag, " pulse width"}, result_valid, 1'b0);
        check({tag, " result held"}, result, exp);
    endtask

    initial begin
        int rv_at;
        int mdv_at;
        bit stall_ok;
        logic stall_k13;

        rst_n   = 1'b0;
        ex_req  = 1'b0;
        ex_op   = 3'd0;
        ex_rs1  = '0;
        ex_rs2  = '0;
        ex_kill = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset result", result, 32'd0);
        check("reset result_valid", result_valid, 1'b0);
        check("reset stall", stall, 1'b0);
        check("reset md_valid", md_valid, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Engine path
        run_op("mul",    3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 1);
        run_op("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 1);
        run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 34, 1);
        run_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 1);
        run_op("div",    3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 34, 1);
        run_op("rem",    3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 34, 1);
        run_op("divu",   3'd5, 32'hFFFF_FFF9, 32'd2,        32'h7FFF_FFFC, 34, 1);

        // Locally resolved cases
        run_op("div0",   3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 1, 0);
        run_op("rem0",   3'd6, 32'd5,         32'd0,         32'd5,         1, 0);
        run_op("divu0",  3'd5, 32'd9,         32'd0,         32'hFFFF_FFFF, 1, 0);
        run_op("remu0",  3'd7, 32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0, 1, 0);
        run_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
        run_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, 0);

        // Kill in BUSY, then a new op presented during DRAIN.
        rv_at     = -1;
        mdv_at    = -1;
        stall_ok  = 1'b1;
        stall_k13 = 1'b1;
        for (int k = 0; k < 120; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                ex_req = 1'b1;
                ex_op  = 3'd0;
                ex_rs1 = 32'd3;
                ex_rs2 = 32'd5;
            end
            if (k == 11) begin
                ex_kill = 1'b1;
                ex_req  = 1'b0;
            end
            if (k == 12) ex_kill = 1'b0;
            if (k == 15) begin
                ex_req = 1'b1;
                ex_op  = 3'd4;
                ex_rs1 = 32'hFFFF_FFF9;
                ex_rs2 = 32'd2;
            end
            @(negedge clk);
            if (k == 13) stall_k13 = stall;
            if (md_valid && k > 0 && mdv_at < 0) mdv_at = k;
            if (result_valid) begin
                rv_at = k;
                break;
            end
            if (k >= 15 && !stall) stall_ok = 1'b0;
        end
        check("kill first result cycle", rv_at, 68);
        check("drain reissue cycle", mdv_at, 34);
        check("drain stall idle pipe", stall_k13, 1'b0);
        check("drain stall with req", stall_ok, 1'b1);
        check("drain result", result, 32'hFFFF_FFFD);
        @(posedge clk); #1;
        ex_req = 1'b0;

        // Asynchronous reset in the middle of BUSY, request still held.
        @(posedge clk); #1;
        ex_req = 1'b1;
        ex_op  = 3'd1;
        ex_rs1 = 32'h1234_5678;
        ex_rs2 = 32'h0000_0100;
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst stall", stall, 1'b0);
        check("rst result", result, 32'd0);
        check("rst result_valid", result_valid, 1'b0);
        check("rst md_valid", md_valid, 1'b0);
        check("rst md_in", {md_mode, md_in_a, md_in_b}, 65'd0);
        ex_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op("post reset mulhu", 3'd3, 32'h1234_5678, 32'h0000_0100, 32'h0000_0012, 34, 1);

        // Same operands twice; reused when the feature is built in.
        run_op("fuse mulh", 3'd1, 32'd3, 32'd5, 32'd0, 34, 1);
`ifdef MULDIV_FUSE_EN
        run_op("fuse mul", 3'd0, 32'd3, 32'd5, 32'd15, 1, 0);
`else
        run_op("fuse mul", 3'd0, 32'd3, 32'd5, 32'd15, 34, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
